// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with oversampling divider feeding a small receive FIFO with sticky error flags
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int W_DIV      = 16
) (
  input  logic                          clk_sys,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [W_DIV-1:0]              clkdiv,
  input  logic                          rx,
  output logic [7:0]                    rdata,
  output logic                          rvalid,
  input  logic                          rready,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [W_DIV-1:0] ctr_q, ctr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ferr_q, ferr_d, ovr_q, ovr_d;
  logic             rx_s, fall, zero, push_req, ferr_set, pop, push, full, ovr_set;
  assign rx_s      = sync_q[1];
  assign fall      = prev_q & ~rx_s;
  assign zero      = ctr_q == '0;
  assign rdata     = mem_q[rd_q];
  assign rvalid    = cnt_q != '0;
  assign level     = cnt_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  // Frame FSM: mid-bit sampling timed by the down-counter; a disable aborts any partial frame
  always_comb begin
    sync_d   = {sync_q[0], rx};
    prev_d   = rx_s;
    state_d  = state_q;
    ctr_d    = ctr_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        ctr_d   = clkdiv >> 1;
        state_d = START;
      end
      START: if (!zero) ctr_d = ctr_q - 1'b1;
      else if (!rx_s) begin
        ctr_d   = clkdiv;
        idx_d   = 3'd0;
        state_d = DATA;
      end else state_d = IDLE;
      DATA: if (!zero) ctr_d = ctr_q - 1'b1;
      else begin
        shift_d = {rx_s, shift_q[7:1]};
        ctr_d   = clkdiv;
        idx_d   = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (!zero) ctr_d = ctr_q - 1'b1;
      else begin
        push_req = rx_s;
        ferr_set = ~rx_s;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d  = IDLE;
      push_req = 1'b0;
      ferr_set = 1'b0;
    end
  end
  // FIFO bookkeeping: a full FIFO still takes a byte when the head leaves in the same cycle
  always_comb begin
    pop     = rvalid & rready;
    full    = cnt_q == FULL;
    push    = push_req & (~full | pop);
    ovr_set = push_req & full & ~pop;
    mem_d   = mem_q;
    if (push) mem_d[wr_q] = shift_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = push == pop ? cnt_q : push ? cnt_q + 1'b1 : cnt_q - 1'b1;
    ferr_d  = ferr_set | (ferr_q & ~err_clr);
    ovr_d   = ovr_set | (ovr_q & ~err_clr);
  end
  // All state registers, cleared asynchronously to the idle line / empty FIFO
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      ctr_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames checked every cycle against a queue-based receiver model
module tb_uart_rx_fifo;
  localparam int D = 4;
  logic        clk_sys = 1'b0, rst_n = 1'b0, enable = 1'b0, rx = 1'b1, rready = 1'b0, err_clr = 1'b0;
  logic [15:0] clkdiv = 16'd9;
  logic [7:0]  rdata;
  logic        rvalid, frame_err, overrun;
  logic [2:0]  level;
  uart_rx_fifo #(.FIFO_DEPTH(D), .W_DIV(16)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .enable(enable), .clkdiv(clkdiv), .rx(rx),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .frame_err(frame_err),
    .overrun(overrun), .err_clr(err_clr), .level(level)
  );
  always #5 clk_sys = ~clk_sys;
  typedef struct {int t; logic [7:0] b; bit stop;} ev_t;
  ev_t        evq[$];
  logic [7:0] mq[$];
  bit         m_ferr, m_ovr;
  int         cyc, n_assert, n_fail;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Model: a frame whose start bit is driven after edge c has its stop bit judged at edge c+4+(clkdiv>>1)+9*(clkdiv+1)
  initial forever begin
    @(posedge clk_sys or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      evq.delete();
      m_ferr = 0;
      m_ovr  = 0;
    end else begin
      bit pop, psh, fe;
      logic [7:0] pb;
      cyc++;
      pop = mq.size() > 0 && rready;
      psh = 0;
      fe  = 0;
      pb  = 8'h00;
      if (evq.size() > 0 && evq[0].t == cyc) begin
        psh = evq[0].stop;
        fe  = !evq[0].stop;
        pb  = evq[0].b;
        void'(evq.pop_front());
      end
      if (err_clr) begin
        m_ferr = 0;
        m_ovr  = 0;
      end
      if (fe) m_ferr = 1;
      if (pop) void'(mq.pop_front());
      if (psh) begin
        if (mq.size() < D) mq.push_back(pb);
        else m_ovr = 1;
      end
    end
  end
  initial forever begin
    @(negedge clk_sys);
    chk("rvalid", {31'd0, rvalid}, {31'd0, mq.size() > 0});
    chk("level", {29'd0, level}, mq.size());
    if (mq.size() > 0) chk("rdata", {24'd0, rdata}, {24'd0, mq[0]});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b, input bit stop = 1'b1, input int nbits = 10);
    logic [9:0] f;
    int p;
    f = {stop, b, 1'b0};
    p = int'(clkdiv) + 1;
    if (nbits == 10) evq.push_back('{cyc + 4 + int'(clkdiv >> 1) + 9 * p, b, stop});
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      tick(p);
    end
    if (nbits == 10) rx = 1'b1;
  endtask
  task automatic pop_expect(input logic [7:0] exp);
    chk("pop_rvalid", {31'd0, rvalid}, 32'd1);
    chk("pop_data", {24'd0, rdata}, {24'd0, exp});
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask
  initial begin
    int t;
    tick(3);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(5);
    send(8'h55);
    tick(3);
    chk("b55_data", {24'd0, rdata}, 32'h55);
    chk("b55_level", {29'd0, level}, 32'd1);
    chk("b55_flags", {30'd0, frame_err, overrun}, 32'd0);
    pop_expect(8'h55);
    send(8'hA3, 1'b0);
    tick(3);
    chk("ferr_set", {31'd0, frame_err}, 32'd1);
    chk("ferr_level", {29'd0, level}, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ferr_clr", {31'd0, frame_err}, 32'd0);
    for (int i = 1; i <= 5; i++) send(8'(i));
    tick(3);
    chk("ovr_level", {29'd0, level}, 32'd4);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 32'd0);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    chk("glitch_level", {29'd0, level}, 32'd0);
    chk("glitch_ferr", {31'd0, frame_err}, 32'd0);
    send(8'h3C);
    tick(3);
    pop_expect(8'h3C);
    for (int i = 1; i <= 4; i++) send(8'(i));
    t = cyc + 4 + 4 + 90;
    fork
      send(8'h05);
      begin
        tick(t - 1 - cyc);
        rready = 1'b1;
        tick();
        rready = 1'b0;
      end
    join
    tick(3);
    chk("fullpop_level", {29'd0, level}, 32'd4);
    chk("fullpop_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 2; i <= 5; i++) pop_expect(8'(i));
    t = cyc + 4 + 4 + 90;
    fork
      send(8'hA3, 1'b0);
      begin
        tick(t - 1 - cyc);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
      end
    join
    tick(2);
    chk("clr_vs_set", {31'd0, frame_err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    send(8'h81, 1'b1, 4);
    enable = 1'b0;
    rx = 1'b1;
    tick(20);
    enable = 1'b1;
    tick(5);
    chk("dis_level", {29'd0, level}, 32'd0);
    send(8'h96);
    tick(3);
    pop_expect(8'h96);
    clkdiv = 16'd5;
    send(8'hC5);
    tick(3);
    pop_expect(8'hC5);
    clkdiv = 16'd9;
    rready = 1'b1;
    tick(3);
    rready = 1'b0;
    chk("empty_pop", {29'd0, level}, 32'd0);
    send(8'hC3, 1'b1, 5);
    rx = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(3);
    chk("midrst_level", {29'd0, level}, 32'd0);
    rx = 1'b1;
    rst_n = 1'b1;
    tick(5);
    send(8'h7E);
    tick(3);
    chk("b7e_level", {29'd0, level}, 32'd1);
    pop_expect(8'h7E);
    chk("b7e_empty", {29'd0, level}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter W_DIV, default 16, width of the bit-period divider.
REQ-003 SHALL have a single clock `clk_sys` (input, 1), with all logic on its rising edge.
REQ-004 SHALL have `rst_n` (input, 1): reset, asynchronous and active-low.
REQ-005 SHALL have `enable` (input, 1): receiver enable.
REQ-006 SHALL have `clkdiv` (input, W_DIV): bit period = clkdiv+1 clk_sys cycles; legal values >=3.
REQ-007 SHALL have `rx` (input, 1): asynchronous serial line, idle high.
REQ-008 SHALL have `rdata` (output, 8): FIFO head byte.
REQ-009 SHALL have `rvalid` (output, 1): FIFO non-empty.
REQ-010 SHALL have `rready` (input, 1): consumer pop; a pop occurs when rvalid && rready.
REQ-011 SHALL have `frame_err` (output, 1): sticky, stop bit sampled low.
REQ-012 SHALL have `overrun` (output, 1): sticky, byte dropped because the FIFO was full.
REQ-013 SHALL have `err_clr` (input, 1): clears both sticky flags.
REQ-014 SHALL have `level` (output, $clog2(FIFO_DEPTH)+1): current FIFO occupancy.

Function
REQ-015 SHALL pass rx through a 2-flop synchroniser reset to 1; the synchronised value is rx_s, and all references to rx below mean rx_s.
REQ-016 SHALL implement states IDLE, START, DATA, STOP with a down-counter `ctr` (W_DIV bits) and a bit index (0..7).
REQ-017 IDLE: on a 1->0 transition of rx_s, SHALL load ctr = clkdiv>>1 and go to START; rx held low on entry to IDLE SHALL NOT start a frame.
REQ-018 START: when ctr==0, SHALL sample rx; low -> load ctr=clkdiv, bit index=0, go to DATA; high -> glitch, return to IDLE with nothing pushed.
REQ-019 DATA: when ctr==0, SHALL shift rx into the byte LSB-first, reload ctr=clkdiv, and after the 8th bit go to STOP; otherwise decrement ctr.
REQ-020 STOP: when ctr==0, SHALL sample rx; high -> push the byte; low -> set frame_err and discard the byte; then go to IDLE in both cases.
REQ-021 SHALL make a pushed byte visible on rdata/rvalid on the cycle after the stop-bit sample edge.
REQ-022 SHALL keep the FIFO first-in first-out, with rdata stable while rvalid && !rready.
REQ-023 SHALL accept a push into a full FIFO if a pop occurs in the same cycle, leaving level unchanged.
REQ-024 For a push into a full FIFO without a pop, SHALL drop the byte, set overrun, and leave FIFO contents unchanged.
REQ-025 On simultaneous push and pop with a non-full FIFO, SHALL leave level unchanged.
REQ-026 SHALL ignore a pop when the FIFO is empty, with no level underflow.
REQ-027 err_clr SHALL clear frame_err and overrun next cycle; a set event in the same cycle as err_clr SHALL win (flag ends set).
REQ-028 enable low SHALL force the FSM to IDLE immediately, discarding any partial frame while retaining FIFO contents, pops and flags.
REQ-029 SHALL apply a clkdiv change from the next ctr load only.

Reset
REQ-030 Asserting rst_n low SHALL immediately set: state IDLE, ctr 0, synchroniser 1s, FIFO empty, level 0, rvalid 0, rdata 0, frame_err 0, overrun 0.
REQ-031 rst_n low mid-frame SHALL abandon the frame, and after release the first frame SHALL be received correctly.

Verification
REQ-032 clkdiv=9, enable=1, send 0x55 8N1 at 10 cycles/bit -> rdata=0x55, rvalid=1, level=1, flags 0.
REQ-033 Send 0xA3 with stop bit low -> frame_err=1, level unchanged; err_clr pulse -> frame_err=0.
REQ-034 FIFO_DEPTH=4, rready=0, send 0x01..0x05 -> level=4, overrun=1, pops yield 0x01,0x02,0x03,0x04.
REQ-035 rx low pulse of 3 cycles at clkdiv=9 -> no push, frame_err=0, FSM back in IDLE.
REQ-036 Full FIFO with rready=1 held on the cycle the 5th byte's stop bit is sampled -> overrun=0, level stays 4, 5th byte read last.
REQ-037 rst_n low during bit 4 of a frame, then released, then send 0x7E -> only 0x7E received.
